// File: rtl/shift_register_pkg.sv
// Shared mode encodings for the universal shift register family.
package shift_register_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROTR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROTL  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'd6;

  // True for the modes that bring a new word into the register.
  function automatic logic is_shift(input logic [MODE_W-1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_fill_counter.sv
// Saturating fill counter, 0..MAX; clr beats set_max beats inc.
module shift_fill_counter #(
  parameter  int unsigned MAX   = 4,
  localparam int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             inc,
  input  logic             set_max,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (set_max) begin
      count <= MAX_C;
    end else if (inc && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign full = (count == MAX_C);

endmodule

// File: rtl/shift_register_universal.sv
// DEPTH x WIDTH universal shift register: hold, shift, rotate, load, clear,
// with an advisory fill count.
module shift_register_universal #(
  parameter  int unsigned WIDTH  = 1,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned MODE_W = 3,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   En,
  input  logic [MODE_W-1:0]      Mode,
  input  logic [WIDTH-1:0]       In,
  input  logic [WIDTH*DEPTH-1:0] Pin,
  output logic [WIDTH-1:0]       Out_R,
  output logic [WIDTH-1:0]       Out_L,
  output logic [WIDTH*DEPTH-1:0] Pout,
  output logic [CNT_W-1:0]       Count,
  output logic                   Full
);

  import shift_register_pkg::*;

  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [DEPTH-1:0][WIDTH-1:0] q_next;
  logic [DEPTH-1:0][WIDTH-1:0] pin_words;

  assign pin_words = Pin;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] lo_shift, lo_rot, hi_shift, hi_rot, nxt;

    // End stages take either the serial input or the wrapped word.
    if (i == 0) begin : g_lo_end
      assign lo_shift = In;
      assign lo_rot   = q[DEPTH-1];
    end else begin : g_lo_mid
      assign lo_shift = q[i-1];
      assign lo_rot   = q[i-1];
    end

    if (i == DEPTH - 1) begin : g_hi_end
      assign hi_shift = In;
      assign hi_rot   = q[0];
    end else begin : g_hi_mid
      assign hi_shift = q[i+1];
      assign hi_rot   = q[i+1];
    end

    always_comb begin
      nxt = q[i];
      case (Mode)
        MODE_SHR:   nxt = lo_shift;
        MODE_SHL:   nxt = hi_shift;
        MODE_LOAD:  nxt = pin_words[i];
        MODE_ROTR:  nxt = lo_rot;
        MODE_ROTL:  nxt = hi_rot;
        MODE_CLEAR: nxt = '0;
        default:    nxt = q[i];
      endcase
    end

    assign q_next[i] = nxt;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      q <= '0;
    end else if (En) begin
      q <= q_next;
    end
  end

  shift_fill_counter #(
    .MAX (DEPTH)
  ) u_fill (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .inc     (En && is_shift(Mode)),
    .set_max (En && (Mode == MODE_LOAD)),
    .clr     (En && (Mode == MODE_CLEAR)),
    .count   (Count),
    .full    (Full)
  );

  assign Out_R = q[DEPTH-1];
  assign Out_L = q[0];
  assign Pout  = q;

endmodule
